// File: rtl/tile_row_renderer.sv
// tile_row_renderer
//   Draws one horizontal row of N_TILES equal character tiles at a fixed
//   origin. It holds a writable character buffer, can blink highlighted tiles,
//   and can rotate the row as a marquee. For every pixel it produces the
//   character code, the sprite ROM address and a highlight flag. All of these
//   outputs appear exactly two clocks after x/y.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   x, y         current pixel column / row
//   frame_start  one-cycle pulse per frame; advances the blink and scroll timers
//   wr_en        write strobe for the character buffer
//   wr_idx       slot to write; slots at or beyond N_TILES are ignored
//   wr_char      character code to store; 0 marks an empty tile
//   hl_mask      per-tile highlight request
//   blink_en     highlight blinks when 1 and is steady when 0
//   scroll_en    marquee rotation enable
//   in_tile      pixel lies in a non-empty tile whose glyph is addressable
//   highlight    pixel lies in a highlighted tile, after blink gating
//   tile_idx     tile under the pixel
//   char_code    character code for the pixel
//   sprite_addr  sprite ROM address of the pixel
module tile_row_renderer #(
    parameter int N_TILES       = 8,
    parameter int IDX_W         = 4,
    parameter int TILE_W        = 50,
    parameter int TILE_H        = 50,
    parameter int GAP           = 0,
    parameter int X0            = 120,
    parameter int Y0            = 215,
    parameter int CHAR_BASE     = 33,
    parameter int BLINK_FRAMES  = 30,
    parameter int SCROLL_FRAMES = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    input  logic                 frame_start,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [7:0]           wr_char,
    input  logic [N_TILES-1:0]   hl_mask,
    input  logic                 blink_en,
    input  logic                 scroll_en,
    output logic                 in_tile,
    output logic                 highlight,
    output logic [IDX_W-1:0]     tile_idx,
    output logic [7:0]           char_code,
    output logic [18:0]          sprite_addr
);

    localparam int PITCH    = TILE_W + GAP;
    localparam int GLYPH_SZ = TILE_W * TILE_H;
    localparam int BC_W     = $clog2(BLINK_FRAMES + 1);
    localparam int SC_W     = $clog2(SCROLL_FRAMES + 1);

    // character buffer and frame timers
    logic [7:0]      buffer_q [N_TILES];
    logic [7:0]      buffer_d [N_TILES];
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic [SC_W-1:0] scroll_cnt_q, scroll_cnt_d;

    // stage 1
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       dx_q, dx_d;
    logic [8:0]       dy_q, dy_d;

    // stage 2 (outputs)
    logic             in_tile_q, in_tile_d;
    logic             highlight_q, highlight_d;
    logic [IDX_W-1:0] tile_idx_q, tile_idx_d;
    logic [7:0]       char_q, char_d;
    logic [18:0]      sprite_addr_q, sprite_addr_d;

    logic [7:0] cur_char;
    logic       cur_hl;
    logic       rotate;

    // Blink timer. While blinking is disabled the timer is held at its
    // start so the first blink period is always full length.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Scroll timer and buffer update. The rotation is applied first, so a
    // write in the same cycle lands in the slot of the rotated buffer.
    always_comb begin
        scroll_cnt_d = scroll_cnt_q;
        rotate       = 1'b0;
        if (!scroll_en) begin
            scroll_cnt_d = '0;
        end else if (frame_start) begin
            if (scroll_cnt_q == SC_W'(SCROLL_FRAMES - 1)) begin
                scroll_cnt_d = '0;
                rotate       = 1'b1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + 1'b1;
            end
        end

        for (int k = 0; k < N_TILES; k++) begin
            buffer_d[k] = rotate ? buffer_q[(k + 1) % N_TILES] : buffer_q[k];
        end
        // the compare loop only covers legal slots, so out-of-range writes
        // fall through untouched
        if (wr_en) begin
            for (int k = 0; k < N_TILES; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    buffer_d[k] = wr_char;
                end
            end
        end
    end

    // Stage 1: locate the tile under the pixel. The bounds are half-open,
    // so at most one tile can match.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        dx_d  = '0;
        dy_d  = '0;
        if ((32'(y) >= Y0) && (32'(y) < Y0 + TILE_H)) begin
            for (int i = 0; i < N_TILES; i++) begin
                if ((32'(x) >= X0 + i * PITCH) && (32'(x) < X0 + i * PITCH + TILE_W)) begin
                    hit_d = 1'b1;
                    idx_d = IDX_W'(i);
                    dx_d  = 10'(32'(x) - (X0 + i * PITCH));
                    dy_d  = 9'(32'(y) - Y0);
                end
            end
        end
    end

    // Stage 2: look up the character and form the outputs. An empty tile or
    // a miss forces every output to zero. A glyph below CHAR_BASE reports its
    // code and index but is never addressed and is never drawn.
    always_comb begin
        cur_char = '0;
        cur_hl   = 1'b0;
        for (int k = 0; k < N_TILES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_char = buffer_q[k];
                cur_hl   = hl_mask[k];
            end
        end

        in_tile_d     = 1'b0;
        highlight_d   = 1'b0;
        tile_idx_d    = '0;
        char_d        = '0;
        sprite_addr_d = '0;
        if (hit_q && (cur_char != 8'd0)) begin
            tile_idx_d = idx_q;
            char_d     = cur_char;
            if (32'(cur_char) >= CHAR_BASE) begin
                in_tile_d     = 1'b1;
                sprite_addr_d = 19'((32'(cur_char) - CHAR_BASE) * GLYPH_SZ
                                    + 32'(dy_q) * TILE_W + 32'(dx_q));
                highlight_d   = cur_hl & (blink_en ? blink_phase_q : 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_TILES; k++) begin
                buffer_q[k] <= '0;
            end
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            scroll_cnt_q  <= '0;
            hit_q         <= 1'b0;
            idx_q         <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            in_tile_q     <= 1'b0;
            highlight_q   <= 1'b0;
            tile_idx_q    <= '0;
            char_q        <= '0;
            sprite_addr_q <= '0;
        end else begin
            for (int k = 0; k < N_TILES; k++) begin
                buffer_q[k] <= buffer_d[k];
            end
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            scroll_cnt_q  <= scroll_cnt_d;
            hit_q         <= hit_d;
            idx_q         <= idx_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            in_tile_q     <= in_tile_d;
            highlight_q   <= highlight_d;
            tile_idx_q    <= tile_idx_d;
            char_q        <= char_d;
            sprite_addr_q <= sprite_addr_d;
        end
    end

    assign in_tile     = in_tile_q;
    assign highlight   = highlight_q;
    assign tile_idx    = tile_idx_q;
    assign char_code   = char_q;
    assign sprite_addr = sprite_addr_q;

endmodule

// File: tb/tb_tile_row_renderer.sv
// Testbench for tile_row_renderer: directed scenarios with literal
// expectations, followed by randomized traffic. Every cycle is checked against
// a behavioural model of the row.
module tb_tile_row_renderer;

    localparam int N             = 8;
    localparam int TILE_W        = 50;
    localparam int TILE_H        = 50;
    localparam int GAP           = 0;
    localparam int PITCH         = TILE_W + GAP;
    localparam int X0            = 120;
    localparam int Y0            = 215;
    localparam int CHAR_BASE     = 33;
    localparam int BLINK_FRAMES  = 30;
    localparam int SCROLL_FRAMES = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        frame_start;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_char;
    logic [7:0]  hl_mask;
    logic        blink_en;
    logic        scroll_en;
    logic        in_tile;
    logic        highlight;
    logic [3:0]  tile_idx;
    logic [7:0]  char_code;
    logic [18:0] sprite_addr;

    always #5 clk = ~clk;

    tile_row_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_char     (wr_char),
        .hl_mask     (hl_mask),
        .blink_en    (blink_en),
        .scroll_en   (scroll_en),
        .in_tile     (in_tile),
        .highlight   (highlight),
        .tile_idx    (tile_idx),
        .char_code   (char_code),
        .sprite_addr (sprite_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model state: the row as the DUT holds it after each clock edge
    int mbuf [N];
    int m_bcnt, m_phase, m_scnt;
    int prev_x, prev_y, prev_valid;
    int e_in, e_hl, e_idx, e_ch, e_addr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) mbuf[k] = 0;
        m_bcnt     = 0;
        m_phase    = 1;
        m_scnt     = 0;
        prev_valid = 0;
    endtask

    // What the row must show for pixel (px,py) given the current buffer.
    task automatic render(input int px, input int py, input int valid,
                          input int hlm, input int ben);
        int off, t, r;
        e_in = 0; e_hl = 0; e_idx = 0; e_ch = 0; e_addr = 0;
        if (valid != 0 && py >= Y0 && py < Y0 + TILE_H && px >= X0) begin
            off = px - X0;
            t   = off / PITCH;
            r   = off % PITCH;
            if (t < N && r < TILE_W && mbuf[t] != 0) begin
                e_idx = t;
                e_ch  = mbuf[t];
                if (mbuf[t] >= CHAR_BASE) begin
                    e_in   = 1;
                    e_addr = ((mbuf[t] - CHAR_BASE) * TILE_W * TILE_H
                              + (py - Y0) * TILE_W + r) % (1 << 19);
                    e_hl   = ((hlm >> t) & 1) & (ben != 0 ? m_phase : 1);
                end
            end
        end
    endtask

    // One clock: predict what appears after this edge, advance the model,
    // then compare on the falling edge.
    task automatic cycle();
        int tmp [N];
        render(prev_x, prev_y, prev_valid, int'(hl_mask), int'(blink_en));

        if (!blink_en) begin
            m_bcnt = 0; m_phase = 1;
        end else if (frame_start) begin
            if (m_bcnt == BLINK_FRAMES - 1) begin m_bcnt = 0; m_phase = 1 - m_phase; end
            else m_bcnt++;
        end
        if (!scroll_en) begin
            m_scnt = 0;
        end else if (frame_start) begin
            if (m_scnt == SCROLL_FRAMES - 1) begin
                for (int k = 0; k < N; k++) tmp[k] = mbuf[(k + 1) % N];
                mbuf   = tmp;
                m_scnt = 0;
            end else m_scnt++;
        end
        if (wr_en && int'(wr_idx) < N) mbuf[wr_idx] = int'(wr_char);

        prev_x = int'(x); prev_y = int'(y); prev_valid = 1;

        @(posedge clk);
        @(negedge clk);
        check("in_tile",     int'(in_tile),     e_in);
        check("highlight",   int'(highlight),   e_hl);
        check("tile_idx",    int'(tile_idx),    e_idx);
        check("char_code",   int'(char_code),   e_ch);
        check("sprite_addr", int'(sprite_addr), e_addr);
    endtask

    task automatic write_slot(input int idx, input int ch);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_char = 8'(ch);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic show(input int px, input int py);
        x = 10'(px); y = 9'(py);
        cycle();
        cycle();
    endtask

    initial begin
        int r;
        reset = 1'b0; x = 10'd175; y = 9'd220;
        frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_char = '0;
        hl_mask = '0; blink_en = 1'b0; scroll_en = 1'b0;
        model_reset();
        prev_x = 0; prev_y = 0;
        repeat (3) @(negedge clk);
        check("rst_in_tile",   int'(in_tile),     0);
        check("rst_highlight", int'(highlight),   0);
        check("rst_tile_idx",  int'(tile_idx),    0);
        check("rst_char",      int'(char_code),   0);
        check("rst_addr",      int'(sprite_addr), 0);
        reset = 1'b1;

        // first glyph
        write_slot(1, 95);
        show(175, 220);
        check("lit_in_tile", int'(in_tile),     1);
        check("lit_idx",     int'(tile_idx),    1);
        check("lit_char",    int'(char_code),   95);
        check("lit_addr",    int'(sprite_addr), 155255);

        // tile edges
        write_slot(0, 65);
        write_slot(1, 66);
        show(169, 220);
        check("edge169_idx",  int'(tile_idx),    0);
        check("edge169_addr", int'(sprite_addr), 80299);
        show(170, 220);
        check("edge170_idx",  int'(tile_idx),    1);
        check("edge170_addr", int'(sprite_addr), 82750);
        show(119, 220);
        check("edge119_in",   int'(in_tile),     0);
        show(175, 265);
        check("edge_y265_in", int'(in_tile),     0);

        // blink
        hl_mask = 8'h02; blink_en = 1'b1;
        show(175, 220);
        check("blink_start", int'(highlight), 1);
        repeat (BLINK_FRAMES) pulse();
        cycle(); cycle();
        check("blink_off", int'(highlight), 0);
        repeat (BLINK_FRAMES) pulse();
        cycle(); cycle();
        check("blink_on", int'(highlight), 1);
        repeat (BLINK_FRAMES) pulse();
        blink_en = 1'b0;
        cycle(); cycle();
        check("blink_dis", int'(highlight), 1);

        // scroll
        for (int k = 0; k < N; k++) write_slot(k, 65 + k);
        scroll_en = 1'b1;
        repeat (SCROLL_FRAMES) pulse();
        show(125, 220);
        check("scroll_slot0", int'(char_code), 66);
        show(475, 220);
        check("scroll_slot7", int'(char_code), 65);
        repeat (SCROLL_FRAMES - 1) pulse();
        frame_start = 1'b1; wr_en = 1'b1; wr_idx = 4'd7; wr_char = 8'd90;
        cycle();
        frame_start = 1'b0; wr_en = 1'b0;
        show(475, 220);
        check("rotwr_slot7", int'(char_code), 90);
        show(125, 220);
        check("rotwr_slot0", int'(char_code), 67);
        scroll_en = 1'b0;

        // illegal input
        write_slot(12, 99);
        show(325, 220);
        check("badidx_slot4", int'(char_code), 71);
        write_slot(2, 20);
        show(225, 220);
        check("lowchar_in",   int'(in_tile),     0);
        check("lowchar_addr", int'(sprite_addr), 0);

        // randomized traffic
        blink_en = 1'b1; scroll_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            x = 10'($urandom_range(100, 560));
            y = 9'($urandom_range(200, 280));
            frame_start = ($urandom_range(0, 2) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_idx = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 9));
            if (r == 0) wr_char = 8'd0;
            else if (r == 1) wr_char = 8'($urandom_range(1, 32));
            else wr_char = 8'($urandom_range(33, 127));
            hl_mask = 8'($urandom);
            if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
            cycle();
        end
        frame_start = 1'b0; wr_en = 1'b0;

        // mid-frame reset while scrolling
        scroll_en = 1'b1; blink_en = 1'b1; hl_mask = 8'hFF;
        for (int k = 0; k < N; k++) write_slot(k, 33 + k * 5);
        show(175, 220);
        check("pre_rst_in", int'(in_tile), 1);
        repeat (5) pulse();
        #2 reset = 1'b0;
        #1;
        check("async_in_tile",   int'(in_tile),     0);
        check("async_highlight", int'(highlight),   0);
        check("async_tile_idx",  int'(tile_idx),    0);
        check("async_char",      int'(char_code),   0);
        check("async_addr",      int'(sprite_addr), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        scroll_en = 1'b0;
        show(175, 220);
        check("post_rst_char", int'(char_code), 0);
        write_slot(1, 95);
        show(175, 220);
        check("post_rst_hl", int'(highlight), 1);
        repeat (BLINK_FRAMES - 1) pulse();
        cycle(); cycle();
        check("post_rst_cnt_hold", int'(highlight), 1);
        pulse();
        cycle(); cycle();
        check("post_rst_cnt_wrap", int'(highlight), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
